systolic_tile_ctrl: RTL and testbench
=====================================

# systolic_tile_ctrl

Parametrised sequencing controller for the systolic-array tile: one start command runs the whole tile pass with no per-cycle enable driving from outside. The pass loads the weight column into the array, streams a programmable number of activation rows, captures the skewed results into the output buffer, then unloads them over a valid/ready handshake. It sits beside the array/buffer datapath and drives that datapath's load/out/write enables.

## Interface
- ARRAY_W, 8: array width; number of weight rows shifted in; skew term.
- K_MAX, 256: maximum activation rows per pass.
- PIPE_LAT, 8: cycles from first streamed activation to first valid result at the output buffer input (≥1).
- KW, $clog2(K_MAX+1): width of k_len.
- One clock; reset is asynchronous and active-low.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  command strobe; accepted only when cmd_ready=1.
- k_len  in  KW  activation rows for this pass; sampled with start.
- abort  in  1  synchronous abort, highest priority after reset.
- cmd_ready  out  1  high in IDLE only.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at pass end.
- weight_buffer_out_en  out  1  high during WLOAD.
- write_weight_en  out  1  high during WLOAD.
- input_buffer_out_en  out  1  high during STREAM.
- output_buffer_load_en  out  1  high during the capture window.
- output_buffer_out_en  out  1  out_valid & out_ready.
- out_valid  out  1  high during UNLOAD.
- out_ready  in  1  downstream accept.

## Operation
- States:
  - IDLE
  - WLOAD: ARRAY_W cycles.
  - STREAM: k_len cycles.
  - DRAIN
  - UNLOAD
  - DONE: 1 cycle, done=1, then IDLE.
- IDLE + start: latch kl = min(k_len, K_MAX); go to WLOAD. If kl=0, go directly to DONE.
- Capture counter t: reset to 0 on the first STREAM cycle, increments every STREAM/DRAIN cycle.
  - STREAM covers t=0..kl-1.
  - output_buffer_load_en = (t ≥ PIPE_LAT) && (t ≤ PIPE_LAT+kl+ARRAY_W-2), i.e. N=kl+ARRAY_W-1 captures.
- STREAM→DRAIN when t=kl-1. DRAIN→UNLOAD after t=PIPE_LAT+kl+ARRAY_W-2. If the capture window ends inside STREAM, DRAIN is still entered for one cycle.
- UNLOAD:
  - out_valid=1; each cycle with out_ready=1 counts one beat.
  - After beat N, go to DONE.
  - out_ready=0 stalls with no state change and no enable pulse.
- Counter widths hold K_MAX+ARRAY_W+PIPE_LAT without wrap; no arithmetic overflow is possible.
- abort in any non-IDLE state: next cycle is IDLE, all enables low, done not pulsed, counters cleared. abort in IDLE is ignored. abort in the same cycle as start: start is ignored.
- start while busy: ignored; not queued.

## Timing
- Reset: every output is 0 except cmd_ready=1. State is IDLE, counters are 0.
- Reset asserted mid-pass: enables drop asynchronously; the pass is lost.
- Cycle numbering: start sampled at edge of cycle 0.
  - WLOAD: cycles 1..ARRAY_W.
  - STREAM: begins at cycle ARRAY_W+1.
  - First capture: cycle ARRAY_W+1+PIPE_LAT.
- UNLOAD begins the cycle after the last capture. With out_ready held high, beats fill N consecutive cycles; DONE follows the last beat.
- cmd_ready returns the cycle after DONE. Back-to-back passes have a 1-cycle IDLE gap minimum.

## Configuration
- SA_WEIGHT_REUSE_EN defined:
  - Adds input port reuse_w (1 bit, sampled with start).
  - Adds internal flag w_loaded: set at WLOAD exit, cleared by reset or abort.
  - start with reuse_w=1 and w_loaded=1 skips WLOAD; STREAM starts at cycle 1.
  - reuse_w=1 with w_loaded=0 performs a normal WLOAD.
- Undefined: port and flag absent; WLOAD always runs.

## Test plan
- ARRAY_W=4, PIPE_LAT=4, k_len=3, out_ready=1 -> WLOAD cycles 1-4; input_buffer_out_en cycles 5-7; load_en cycles 9-14 (6 pulses); out beats cycles 15-20; done at cycle 21; cmd_ready=1 at cycle 22.
- Same config, out_ready toggling 1,0,1,0… in UNLOAD -> exactly 6 output_buffer_out_en pulses, none while out_ready=0; done one cycle after the 6th.
- k_len=0 -> done at cycle 1; no enable ever asserted. k_len=K_MAX+5 -> exactly K_MAX input_buffer_out_en pulses.
- abort at cycle 6 of the 3-row pass -> cycle 7 in IDLE: all enables 0, cmd_ready=1, no done. Reset pulse mid-STREAM -> all outputs 0 immediately.
- start asserted during STREAM -> ignored; the pass completes with the original k_len.
- SA_WEIGHT_REUSE_EN: pass 1 normal; pass 2 with reuse_w=1 -> write_weight_en never high, STREAM at cycle 1. After abort, reuse_w=1 -> WLOAD runs.

Source files
------------

// File: rtl/systolic_tile_ctrl_if.sv
// ---------------------------------------------------------------------------
// systolic_tile_ctrl_if
//   Command / datapath-enable bundle between a host and systolic_tile_ctrl.
//
//   Parameters
//     KW : width of k_len (activation rows per pass)
//
//   Signals
//     start, k_len, abort         host -> controller command strobe / length / abort
//     cmd_ready, busy, done       controller -> host status
//     weight_buffer_out_en,
//     write_weight_en             WLOAD enables
//     input_buffer_out_en         STREAM enable
//     output_buffer_load_en       capture window enable
//     output_buffer_out_en        unload beat (out_valid & out_ready)
//     out_valid / out_ready       unload handshake
//     reuse_w                     only with SA_WEIGHT_REUSE_EN: skip WLOAD when
//                                 weights are already resident
//
//   Modports
//     master : host / testbench side
//     slave  : controller side
// ---------------------------------------------------------------------------
interface systolic_tile_ctrl_if #(
  parameter int KW = 9
);
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
`ifdef SA_WEIGHT_REUSE_EN
  logic          reuse_w;
`endif
  logic          cmd_ready;
  logic          busy;
  logic          done;
  logic          weight_buffer_out_en;
  logic          write_weight_en;
  logic          input_buffer_out_en;
  logic          output_buffer_load_en;
  logic          output_buffer_out_en;
  logic          out_valid;
  logic          out_ready;

  modport master (
`ifdef SA_WEIGHT_REUSE_EN
    output reuse_w,
`endif
    output start, k_len, abort, out_ready,
    input  cmd_ready, busy, done,
    input  weight_buffer_out_en, write_weight_en, input_buffer_out_en,
    input  output_buffer_load_en, output_buffer_out_en, out_valid
  );

  modport slave (
`ifdef SA_WEIGHT_REUSE_EN
    input  reuse_w,
`endif
    input  start, k_len, abort, out_ready,
    output cmd_ready, busy, done,
    output weight_buffer_out_en, write_weight_en, input_buffer_out_en,
    output output_buffer_load_en, output_buffer_out_en, out_valid
  );
endinterface

// File: rtl/systolic_tile_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_tile_ctrl
//   Sequencer for one systolic-array tile pass: a single start command walks
//   WLOAD -> STREAM -> DRAIN -> UNLOAD -> DONE and drives the datapath enables.
//
//   Parameters
//     ARRAY_W  : array width (weight rows shifted in, result skew)
//     K_MAX    : maximum activation rows per pass (k_len is clamped to it)
//     PIPE_LAT : cycles from first streamed activation to first result (>=1)
//     KW       : width of k_len
//
//   Ports
//     clk  : clock, rising edge
//     rst  : asynchronous reset, active low
//     bus  : systolic_tile_ctrl_if.slave (command, status, enables, handshake)
//
//   Optional feature macro: SA_WEIGHT_REUSE_EN
//     Adds bus.reuse_w and a w_loaded flag; a start with reuse_w=1 while the
//     weights are still resident skips WLOAD and goes straight to STREAM.
//     Without the macro WLOAD always runs.
// ---------------------------------------------------------------------------
module systolic_tile_ctrl #(
  parameter int ARRAY_W  = 8,
  parameter int K_MAX    = 256,
  parameter int PIPE_LAT = 8,
  parameter int KW       = $clog2(K_MAX + 1)
) (
  input logic                clk,
  input logic                rst,
  systolic_tile_ctrl_if.slave bus
);

  // t and the beat counter must hold K_MAX+ARRAY_W+PIPE_LAT without wrapping.
  localparam int TW = $clog2(K_MAX + ARRAY_W + PIPE_LAT + 1);
  localparam int WW = $clog2(ARRAY_W + 1);

  localparam logic [KW-1:0] KMAX_K = KW'(K_MAX);
  localparam logic [WW-1:0] WLAST  = WW'(ARRAY_W - 1);
  localparam logic [TW-1:0] PIPE_T = TW'(PIPE_LAT);
  localparam logic [TW-1:0] TAIL_T = TW'(PIPE_LAT + ARRAY_W - 2);
  localparam logic [TW-1:0] SKEW_T = TW'(ARRAY_W - 1);
  localparam logic [TW-1:0] ONE_T  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_STREAM,
    S_DRAIN,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] kl_q, kl_d;
  logic [WW-1:0] wc_q, wc_d;
  logic [TW-1:0] t_q, t_d;
  logic [TW-1:0] beat_q, beat_d;
`ifdef SA_WEIGHT_REUSE_EN
  logic          w_loaded_q, w_loaded_d;
`endif

  logic [KW-1:0] kl_sel;
  logic [TW-1:0] kl_ext;
  logic [TW-1:0] t_last;      // last t of the capture window
  logic [TW-1:0] stream_last; // last t of STREAM
  logic [TW-1:0] n_beats;     // N = kl + ARRAY_W - 1
  logic          skip_wload;
  logic          accept;
  logic          in_window;

  assign kl_sel      = (bus.k_len > KMAX_K) ? KMAX_K : bus.k_len;
  assign kl_ext      = TW'(kl_q);
  assign t_last      = kl_ext + TAIL_T;
  assign stream_last = kl_ext - ONE_T;
  assign n_beats     = kl_ext + SKEW_T;

  // abort wins over a coincident start.
  assign accept = bus.start && !bus.abort;

`ifdef SA_WEIGHT_REUSE_EN
  assign skip_wload = bus.reuse_w && w_loaded_q;
`else
  assign skip_wload = 1'b0;
`endif

  // ------------------------------------------------------------------ state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      kl_q       <= '0;
      wc_q       <= '0;
      t_q        <= '0;
      beat_q     <= '0;
`ifdef SA_WEIGHT_REUSE_EN
      w_loaded_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      kl_q       <= kl_d;
      wc_q       <= wc_d;
      t_q        <= t_d;
      beat_q     <= beat_d;
`ifdef SA_WEIGHT_REUSE_EN
      w_loaded_q <= w_loaded_d;
`endif
    end
  end

  // ------------------------------------------------------------- next state
  always_comb begin
    state_d    = state_q;
    kl_d       = kl_q;
    wc_d       = wc_q;
    t_d        = t_q;
    beat_d     = beat_q;
`ifdef SA_WEIGHT_REUSE_EN
    w_loaded_d = w_loaded_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          kl_d   = kl_sel;
          wc_d   = '0;
          t_d    = '0;
          beat_d = '0;
          if (kl_sel == '0) begin
            state_d = S_DONE;
          end else if (skip_wload) begin
            state_d = S_STREAM;
          end else begin
            state_d = S_WLOAD;
          end
        end
      end

      S_WLOAD: begin
        if (wc_q == WLAST) begin
          state_d    = S_STREAM;
          wc_d       = '0;
          t_d        = '0;
`ifdef SA_WEIGHT_REUSE_EN
          w_loaded_d = 1'b1;
`endif
        end else begin
          wc_d = wc_q + 1'b1;
        end
      end

      S_STREAM: begin
        t_d = t_q + ONE_T;
        // DRAIN is always visited, even when the capture window has already
        // closed by the end of STREAM.
        if (t_q == stream_last) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        t_d = t_q + ONE_T;
        if (t_q >= t_last) begin
          state_d = S_UNLOAD;
          beat_d  = '0;
        end
      end

      S_UNLOAD: begin
        if (bus.out_ready) begin
          beat_d = beat_q + ONE_T;
          if (beat_d == n_beats) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        kl_d    = '0;
        wc_d    = '0;
        t_d     = '0;
        beat_d  = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort clears the pass from any busy state; in IDLE it has no effect.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      kl_d       = '0;
      wc_d       = '0;
      t_d        = '0;
      beat_d     = '0;
`ifdef SA_WEIGHT_REUSE_EN
      w_loaded_d = 1'b0;
`endif
    end
  end

  // ---------------------------------------------------------------- outputs
  // All outputs decode state_q, so an asynchronous reset drops them at once.
  assign in_window = ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                     (t_q >= PIPE_T) && (t_q <= t_last);

  assign bus.cmd_ready             = (state_q == S_IDLE);
  assign bus.busy                  = (state_q != S_IDLE);
  assign bus.done                  = (state_q == S_DONE);
  assign bus.weight_buffer_out_en  = (state_q == S_WLOAD);
  assign bus.write_weight_en       = (state_q == S_WLOAD);
  assign bus.input_buffer_out_en   = (state_q == S_STREAM);
  assign bus.output_buffer_load_en = in_window;
  assign bus.out_valid             = (state_q == S_UNLOAD);
  assign bus.output_buffer_out_en  = (state_q == S_UNLOAD) && bus.out_ready;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
module tb_systolic_tile_ctrl;
  localparam int AW = 4;
  localparam int PL = 4;
  localparam int KM = 16;
  localparam int KW = $clog2(KM + 1);
  localparam logic [8:0] IDLE_V = 9'b1_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_tile_ctrl_if #(.KW(KW)) bus ();

  systolic_tile_ctrl #(
    .ARRAY_W (AW),
    .K_MAX   (KM),
    .PIPE_LAT(PL),
    .KW      (KW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];

  // {cmd_ready, busy, done, wbuf_en, wwr_en, ibuf_en, obuf_ld, obuf_out, out_valid}
  function automatic logic [8:0] obs_vec();
    return {bus.cmd_ready, bus.busy, bus.done, bus.weight_buffer_out_en,
            bus.write_weight_en, bus.input_buffer_out_en,
            bus.output_buffer_load_en, bus.output_buffer_out_en, bus.out_valid};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One pass. mode 0: out_ready held high; mode 1: out_ready toggles 1,0,...
  // from the first UNLOAD cycle. abort_c / restart_c: cycle to pulse abort /
  // a spurious start (0 = never).
  task automatic run_pass(input int klen, input int mode, input int abort_c,
                          input int restart_c, input string tag);
    int kl, n, u, beats, done_c, c;
    int ien_cnt, ld_cnt, oen_cnt, done_cnt, wen_cnt;
    logic rdy, e_w, e_i, e_l, e_v, e_o, e_d, e_busy;
    logic [8:0] e, e_pop;
    kl = (klen > KM) ? KM : klen;
    n  = kl + AW - 1;
    u  = AW + PL + n + 1;
    beats = 0;
    done_c = (kl == 0) ? 1 : -1;
    ien_cnt = 0; ld_cnt = 0; oen_cnt = 0; done_cnt = 0; wen_cnt = 0;

    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = KW'(klen);
    @(posedge clk);
    #1;
    c = 1;
    while (1) begin
      rdy = (mode == 0) ? 1'b1 : ((c >= u) ? (((c - u) % 2) == 0) : 1'b1);
      bus.out_ready = rdy;
      bus.abort     = (c == abort_c);
      if (c == restart_c) begin
        bus.start = 1'b1;
        bus.k_len = KW'(7);
      end else begin
        bus.start = 1'b0;
      end

      if (abort_c > 0 && c > abort_c) begin
        e = IDLE_V;
      end else begin
        e_w    = (kl > 0) && (c <= AW);
        e_i    = (kl > 0) && (c >= AW + 1) && (c <= AW + kl);
        e_l    = (kl > 0) && (c >= AW + 1 + PL) && (c <= AW + PL + n);
        e_v    = (kl > 0) && (c >= u) && (beats < n);
        e_o    = e_v && rdy;
        e_d    = (c == done_c);
        e_busy = (done_c < 0) || (c <= done_c);
        e = {!e_busy, e_busy, e_d, e_w, e_w, e_i, e_l, e_o, e_v};
        if (e_o) begin
          beats++;
          if (beats == n) done_c = c + 1;
        end
      end
      exp_q.push_back(e);

      @(negedge clk);
      e_pop = exp_q.pop_front();
      check($sformatf("%s_c%0d", tag, c), 32'(obs_vec()), 32'(e_pop));
      ien_cnt  += int'(bus.input_buffer_out_en);
      ld_cnt   += int'(bus.output_buffer_load_en);
      oen_cnt  += int'(bus.output_buffer_out_en);
      done_cnt += int'(bus.done);
      wen_cnt  += int'(bus.write_weight_en);

      if (abort_c > 0 && c == abort_c + 1) break;
      if (done_c > 0 && c == done_c + 1) break;
      if (c > 600) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout observed=no_done expected=done_within_600", tag);
        break;
      end
      c++;
      @(posedge clk);
      #1;
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;

    if (abort_c == 0) begin
      check({tag, "_ien_cnt"},  32'(ien_cnt),  32'(kl));
      check({tag, "_ld_cnt"},   32'(ld_cnt),   32'((kl > 0) ? n : 0));
      check({tag, "_oen_cnt"},  32'(oen_cnt),  32'((kl > 0) ? n : 0));
      check({tag, "_wen_cnt"},  32'(wen_cnt),  32'((kl > 0) ? AW : 0));
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'(1));
    end else begin
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'(0));
    end
    $display("pass %s: k_len=%0d ien=%0d ld=%0d beats=%0d done=%0d cycles=%0d",
             tag, klen, ien_cnt, ld_cnt, oen_cnt, done_cnt, c);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
`ifdef SA_WEIGHT_REUSE_EN
    bus.reuse_w = 1'b0;
`endif

    #1;
    check("reset_outputs", 32'(obs_vec()), 32'(IDLE_V));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'(obs_vec()), 32'(IDLE_V));

    run_pass(3, 0, 0, 0, "kl3");
    run_pass(3, 1, 0, 0, "kl3_toggle");
    run_pass(0, 0, 0, 0, "kl0");
    run_pass(KM + 5, 0, 0, 0, "kl_over");
    run_pass(3, 0, 6, 0, "abort");
    run_pass(3, 0, 0, 6, "start_busy");

    // Asynchronous reset in the middle of STREAM.
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = KW'(3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre_reset_stream", 32'(bus.input_buffer_out_en), 32'(1));
    rst = 1'b0;
    #1;
    check("mid_reset_outputs", 32'(obs_vec()), 32'(IDLE_V));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("after_reset_idle", 32'(obs_vec()), 32'(IDLE_V));

    run_pass(2, 0, 0, 0, "recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
